// File: rtl/sysctrl_irq.sv
// Interrupt controller for the MCU system-control channel: latches source events
// into pending bits, masks them onto int_in and suppresses int_in after each ack.
module sysctrl_irq #(
    parameter int unsigned N          = 8,
    parameter logic [7:0]  LEVEL_MASK = 8'h00,
    parameter int unsigned HOLDOFF    = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] src_irq,
    input  logic         mask_wr,
    input  logic [N-1:0] mask_data,
    input  logic [7:0]   int_ack,
    output logic [7:0]   int_in,
    output logic [N-1:0] irq_pending,
    output logic [N-1:0] irq_ovf,
    output logic         holdoff_active
);

    localparam int unsigned    CNT_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [N-1:0]   LVL     = LEVEL_MASK[N-1:0];
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF);

    logic [N-1:0]     src_prev_q, src_prev_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     ovf_q, ovf_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]     ack_n;
    logic [N-1:0]     rise;
    logic [N-1:0]     set;
    logic [N-1:0]     visible;

    // Next-state logic for event capture, overflow, mask and hold-off counter
    always_comb begin
        ack_n      = int_ack[N-1:0];
        rise       = src_irq & ~src_prev_q;
        set        = (LVL & src_irq) | (~LVL & rise);
        src_prev_d = src_irq;
        // Set wins over a coincident ack; ack wins over a coincident overflow
        pending_d  = set | (pending_q & ~ack_n);
        ovf_d      = (ovf_q & ~ack_n) | (rise & pending_q & ~ack_n & ~LVL);
        mask_d     = mask_wr ? mask_data : mask_q;
        cnt_d      = cnt_q;
        if (int_ack != 8'h00) begin
            cnt_d = HOLD_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            ovf_q      <= '0;
            mask_q     <= '1;
            cnt_q      <= '0;
        end else begin
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs depend on registers only
    always_comb begin
        visible        = pending_q & mask_q;
        holdoff_active = (cnt_q != '0);
        int_in         = holdoff_active ? 8'h00 : 8'(visible);
        irq_pending    = pending_q;
        irq_ovf        = ovf_q;
    end

endmodule

// File: tb/tb_sysctrl_irq.sv
// Directed bench for sysctrl_irq: vector table on a level/hold-off=16 instance,
// plus hand sequences for reset mid-operation and a hold-off=0 instance.
module tb_sysctrl_irq;

    typedef struct {
        logic [7:0] src;
        logic       mwr;
        logic [7:0] mdata;
        logic [7:0] ack;
        int         reps;
        logic [7:0] e_int;
        logic [7:0] e_pend;
        logic [7:0] e_ovf;
        logic       e_hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic [7:0] int_ack;

    logic [7:0] a_int, a_pend, a_ovf;
    logic       a_hold;
    logic [7:0] b_int, b_pend, b_ovf;
    logic       b_hold;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    sysctrl_irq #(.N(8), .LEVEL_MASK(8'h80), .HOLDOFF(16)) dut_a (
        .clk(clk), .reset(reset), .src_irq(src), .mask_wr(mask_wr),
        .mask_data(mask_data), .int_ack(int_ack), .int_in(a_int),
        .irq_pending(a_pend), .irq_ovf(a_ovf), .holdoff_active(a_hold)
    );

    sysctrl_irq #(.N(8), .LEVEL_MASK(8'h00), .HOLDOFF(0)) dut_b (
        .clk(clk), .reset(reset), .src_irq(src), .mask_wr(mask_wr),
        .mask_data(mask_data), .int_ack(int_ack), .int_in(b_int),
        .irq_pending(b_pend), .irq_ovf(b_ovf), .holdoff_active(b_hold)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] ei, input logic [7:0] ep,
                         input logic [7:0] eo, input logic eh);
        chk({tag, " int_in"}, a_int, ei);
        chk({tag, " pending"}, a_pend, ep);
        chk({tag, " ovf"}, a_ovf, eo);
        chk({tag, " holdoff"}, {7'd0, a_hold}, {7'd0, eh});
    endtask

    task automatic chk_b(input string tag, input logic [7:0] ei, input logic [7:0] ep);
        chk({tag, " b int_in"}, b_int, ei);
        chk({tag, " b pending"}, b_pend, ep);
        chk({tag, " b holdoff"}, {7'd0, b_hold}, 8'h00);
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic w, input logic [7:0] md,
                                input logic [7:0] ak, input int r, input logic [7:0] ei,
                                input logic [7:0] ep, input logic [7:0] eo, input logic eh);
        vec_t v;
        v.src = s; v.mwr = w; v.mdata = md; v.ack = ak; v.reps = r;
        v.e_int = ei; v.e_pend = ep; v.e_ovf = eo; v.e_hold = eh;
        return v;
    endfunction

    initial begin
        // src, mask_wr, mask_data, ack, reps | int_in, pending, ovf, holdoff
        // Edge path on source 2 and hold-off after its ack
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 0));
        vq.push_back(mk(8'h04, 0, 8'h00, 8'h00,  1, 8'h04, 8'h04, 8'h00, 0));
        vq.push_back(mk(8'h04, 0, 8'h00, 8'h00,  3, 8'h04, 8'h04, 8'h00, 0));
        vq.push_back(mk(8'h04, 0, 8'h00, 8'h04,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 15, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  1, 8'h00, 8'h00, 8'h00, 0));
        // Overflow on source 0, ack clears, coincident pulse+ack
        vq.push_back(mk(8'h01, 0, 8'h00, 8'h00,  1, 8'h01, 8'h01, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  1, 8'h01, 8'h01, 8'h00, 0));
        vq.push_back(mk(8'h01, 0, 8'h00, 8'h00,  1, 8'h01, 8'h01, 8'h01, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h01,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h01, 0, 8'h00, 8'h00,  1, 8'h00, 8'h01, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  1, 8'h00, 8'h01, 8'h00, 1));
        vq.push_back(mk(8'h01, 0, 8'h00, 8'h01,  1, 8'h00, 8'h01, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 16, 8'h01, 8'h01, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h01,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 16, 8'h00, 8'h00, 8'h00, 0));
        // Mask: masked source still pends, unmask exposes it next cycle
        vq.push_back(mk(8'h00, 1, 8'hFE, 8'h00,  1, 8'h00, 8'h00, 8'h00, 0));
        vq.push_back(mk(8'h01, 0, 8'h00, 8'h00,  1, 8'h00, 8'h01, 8'h00, 0));
        vq.push_back(mk(8'h00, 1, 8'hFF, 8'h00,  1, 8'h01, 8'h01, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h01,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 16, 8'h00, 8'h00, 8'h00, 0));
        // Level source 7: re-pends through the ack, visible 16 cycles later
        vq.push_back(mk(8'h80, 0, 8'h00, 8'h00,  1, 8'h80, 8'h80, 8'h00, 0));
        vq.push_back(mk(8'h80, 0, 8'h00, 8'h80,  1, 8'h00, 8'h80, 8'h00, 1));
        vq.push_back(mk(8'h80, 0, 8'h00, 8'h00, 15, 8'h00, 8'h80, 8'h00, 1));
        vq.push_back(mk(8'h80, 0, 8'h00, 8'h00,  1, 8'h80, 8'h80, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h80,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 16, 8'h00, 8'h00, 8'h00, 0));
        // Hold-off reload: second ack 10 cycles later restarts the window
        vq.push_back(mk(8'h06, 0, 8'h00, 8'h00,  1, 8'h06, 8'h06, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h02,  1, 8'h00, 8'h04, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  9, 8'h00, 8'h04, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h02,  1, 8'h00, 8'h04, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 15, 8'h00, 8'h04, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00,  1, 8'h04, 8'h04, 8'h00, 0));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h04,  1, 8'h00, 8'h00, 8'h00, 1));
        vq.push_back(mk(8'h00, 0, 8'h00, 8'h00, 16, 8'h00, 8'h00, 8'h00, 0));

        reset = 1'b1; src = 8'h00; mask_wr = 1'b0; mask_data = 8'h00; int_ack = 8'h00;
        step();
        chk_a("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk_b("reset", 8'h00, 8'h00);
        reset = 1'b0;

        foreach (vq[i]) begin
            src = vq[i].src; mask_wr = vq[i].mwr; mask_data = vq[i].mdata; int_ack = vq[i].ack;
            step();
            mask_wr = 1'b0; int_ack = 8'h00;
            for (int r = 1; r < vq[i].reps; r++) step();
            chk_a($sformatf("row%0d", i), vq[i].e_int, vq[i].e_pend, vq[i].e_ovf, vq[i].e_hold);
        end

        // Reset mid-operation with pending, overflow, cleared mask bit and running counter
        src = 8'h01; step();
        src = 8'h00; step();
        src = 8'h01; step();
        mask_wr = 1'b1; mask_data = 8'hFE; step();
        mask_wr = 1'b0;
        src = 8'h0F; step();
        chk_a("pre-reset", 8'h0E, 8'h0F, 8'h01, 1'b0);
        int_ack = 8'h10; step();
        int_ack = 8'h00;
        chk_a("pre-reset ack", 8'h00, 8'h0F, 8'h01, 1'b1);
        src = 8'h09; reset = 1'b1; step();
        chk_a("mid-reset", 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0; step();
        chk_a("post-reset", 8'h09, 8'h09, 8'h00, 1'b0);

        // Hold-off disabled instance: acks never suppress remaining bits
        reset = 1'b1; src = 8'h00; step();
        reset = 1'b0; step();
        chk_b("b idle", 8'h00, 8'h00);
        src = 8'h03; step();
        chk_b("b set", 8'h03, 8'h03);
        int_ack = 8'h01; step();
        int_ack = 8'h00;
        chk_b("b ack0", 8'h02, 8'h02);
        step();
        chk_b("b hold", 8'h02, 8'h02);
        int_ack = 8'h02; step();
        int_ack = 8'h00;
        chk_b("b ack1", 8'h00, 8'h00);
        src = 8'h00; step();
        src = 8'h06; step();
        chk_b("b set2", 8'h06, 8'h06);
        src = 8'h00; int_ack = 8'h02; step();
        int_ack = 8'h00;
        chk_b("b ackA", 8'h04, 8'h04);
        for (int r = 0; r < 9; r++) step();
        int_ack = 8'h02; step();
        int_ack = 8'h00;
        chk_b("b ackB", 8'h04, 8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
